// File: rtl/cdc_evt_pkg.sv
// cdc_evt_pkg: shared state encoding, default widths and the saturating next-count helper
package cdc_evt_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RET  = 3'b100
    } state_t;
    localparam int CNT_W_DEF = 4;
    localparam int TMO_W_DEF = 8;
    function automatic int unsigned sat_next(input int unsigned cnt, input int unsigned max,
                                             input logic inc, input logic dec);
        return (inc && !dec) ? ((cnt == max) ? cnt : cnt + 1) : ((dec && !inc) ? cnt - 1 : cnt);
    endfunction
endpackage

// File: rtl/cdc_evt_pend_cnt.sv
// cdc_evt_pend_cnt: saturating up/down pending-event counter with sticky overflow flag
module cdc_evt_pend_cnt
    import cdc_evt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    localparam int unsigned MAX = (32'd1 << CNT_W) - 32'd1;
    logic drop;
    assign drop = inc && !dec && (cnt == {CNT_W{1'b1}});
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= CNT_W'(sat_next(32'(cnt), MAX, inc, dec));
            ovf <= drop | (ovf & ~clr);
        end
    end
endmodule

// File: rtl/cdc_evt_req_gen.sv
// cdc_evt_req_gen: four-phase request generator with queued events.
// Define CDC_EVT_TIMEOUT_EN to add the handshake timeout and tmo_o.
module cdc_evt_req_gen
    import cdc_evt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             evt_i,
    input  logic             ack_i,
    input  logic             ovf_clr_i,
    output logic             req_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic             ovf_o
`ifdef CDC_EVT_TIMEOUT_EN
    ,
    output logic             tmo_o
`endif
);
    state_t state, state_nxt;
    logic   launch;
    // a stale ack left over from an earlier handshake blocks launching
    assign launch = (state == ST_IDLE) && (pend_cnt_o != '0) && !ack_i;
    assign req_o  = state[1];
    assign busy_o = (state != ST_IDLE) || (pend_cnt_o != '0);
    cdc_evt_pend_cnt #(.CNT_W(CNT_W)) u_pend (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (evt_i),
        .dec   (launch),
        .clr   (ovf_clr_i),
        .cnt   (pend_cnt_o),
        .ovf   (ovf_o)
    );
`ifdef CDC_EVT_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // the abort edge is the one at which the counter would reach all-ones
    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tmo_cnt <= '0;
            tmo_o   <= 1'b0;
        end else begin
            tmo_cnt <= (state_nxt != state || state == ST_IDLE) ? '0 : tmo_cnt + 1'b1;
            tmo_o   <= tmo_hit | (tmo_o & ~ovf_clr_i);
        end
    end
`else
    logic unused_tmo_w;
    assign unused_tmo_w = ^TMO_W;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = launch ? ST_REQ : ST_IDLE;
            ST_REQ:  state_nxt = ack_i ? ST_RET : ST_REQ;
            ST_RET:  state_nxt = ack_i ? ST_RET : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
`ifdef CDC_EVT_TIMEOUT_EN
        if (tmo_hit) state_nxt = ST_IDLE;
`endif
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_IDLE;
        else state <= state_nxt;
    end
endmodule

// File: tb/tb_cdc_evt_req_gen.sv
// tb_cdc_evt_req_gen: directed tests with a delayed ack loopback; dut2 uses CNT_W=2 for saturation.
module tb_cdc_evt_req_gen;
    logic clk = 1'b0, rst_b = 1'b0;
    logic evt = 1'b0, ack = 1'b0, clr = 1'b0, req, busy, ovf;
    logic [3:0] cnt;
    logic evt2 = 1'b0, ack2 = 1'b0, clr2 = 1'b0, req2, busy2, ovf2;
    logic [1:0] cnt2;
`ifdef CDC_EVT_TIMEOUT_EN
    logic tmo, tmo2;
`endif
    int checks = 0, errors = 0;
    logic loop_en = 1'b0;
    int dly = 1;
    logic [15:0] hist = '0;
    int edges = 0;
    logic req_prev = 1'b0;
    logic [3:0] peak = '0;

    cdc_evt_req_gen #(.CNT_W(4), .TMO_W(3)) dut (
        .clk(clk), .rst_b(rst_b), .evt_i(evt), .ack_i(ack), .ovf_clr_i(clr),
        .req_o(req), .busy_o(busy), .pend_cnt_o(cnt), .ovf_o(ovf)
`ifdef CDC_EVT_TIMEOUT_EN
        , .tmo_o(tmo)
`endif
    );
    cdc_evt_req_gen #(.CNT_W(2), .TMO_W(3)) dut2 (
        .clk(clk), .rst_b(rst_b), .evt_i(evt2), .ack_i(ack2), .ovf_clr_i(clr2),
        .req_o(req2), .busy_o(busy2), .pend_cnt_o(cnt2), .ovf_o(ovf2)
`ifdef CDC_EVT_TIMEOUT_EN
        , .tmo_o(tmo2)
`endif
    );

    always #5 clk = ~clk;

    task cyc;
        @(negedge clk);
        hist = {hist[14:0], req};
        if (req && !req_prev) edges++;
        req_prev = req;
        if (cnt > peak) peak = cnt;
        if (loop_en) ack = hist[dly-1];
    endtask

    task clr_stats;
        edges = 0;
        peak = '0;
    endtask

    task test_reset;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", req); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        checks++; if (cnt2 !== 2'd0 || req2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got cnt=%0d req=%0b want 0/0", cnt2, req2); end
`ifdef CDC_EVT_TIMEOUT_EN
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo got %0b want 0", tmo); end
`endif
        rst_b = 1'b1;
    endtask

    task test_single;
        clr_stats();
        loop_en = 1'b1;
        dly = 3;
        evt = 1'b1;
        cyc();
        evt = 1'b0;
        checks++; if (cnt !== 4'd1 || req !== 1'b0) begin errors++; $display("FAIL single_edge1 got cnt=%0d req=%0b want 1/0", cnt, req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        cyc();
        checks++; if (req !== 1'b1 || cnt !== 4'd0) begin errors++; $display("FAIL single_edge2 got req=%0b cnt=%0d want 1/0", req, cnt); end
        repeat (14) cyc();
        checks++; if (edges != 1) begin errors++; $display("FAIL single_edges got %0d want 1", edges); end
        checks++; if (req !== 1'b0 || cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got req=%0b cnt=%0d busy=%0b want 0/0/0", req, cnt, busy); end
    endtask

    task test_burst;
        clr_stats();
        dly = 6;
        evt = 1'b1;
        repeat (5) cyc();
        evt = 1'b0;
        checks++; if (peak !== 4'd4) begin errors++; $display("FAIL burst_peak got %0d want 4", peak); end
        repeat (100) cyc();
        checks++; if (edges != 5) begin errors++; $display("FAIL burst_edges got %0d want 5", edges); end
        checks++; if (cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL burst_done got cnt=%0d busy=%0b want 0/0", cnt, busy); end
    endtask

    task test_simultaneous;
        clr_stats();
        dly = 1;
        evt = 1'b1;
        cyc();
        cyc();
        evt = 1'b0;
        checks++; if (cnt !== 4'd1 || req !== 1'b1) begin errors++; $display("FAIL simul_launch got cnt=%0d req=%0b want 1/1", cnt, req); end
        repeat (40) cyc();
        checks++; if (edges != 2) begin errors++; $display("FAIL simul_edges got %0d want 2", edges); end
        checks++; if (cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL simul_done got cnt=%0d busy=%0b want 0/0", cnt, busy); end
    endtask

    task test_saturation;
        ack2 = 1'b0;
        evt2 = 1'b1;
        repeat (4) cyc();
        checks++; if (cnt2 !== 2'd3 || ovf2 !== 1'b0 || req2 !== 1'b1) begin errors++; $display("FAIL sat_full got cnt=%0d ovf=%0b req=%0b want 3/0/1", cnt2, ovf2, req2); end
        cyc();
        checks++; if (cnt2 !== 2'd3 || ovf2 !== 1'b1) begin errors++; $display("FAIL sat_drop got cnt=%0d ovf=%0b want 3/1", cnt2, ovf2); end
        repeat (2) cyc();
        clr2 = 1'b1;
        cyc();
        checks++; if (ovf2 !== 1'b1 || cnt2 !== 2'd3) begin errors++; $display("FAIL sat_set_wins got ovf=%0b cnt=%0d want 1/3", ovf2, cnt2); end
        evt2 = 1'b0;
        cyc();
        clr2 = 1'b0;
        checks++; if (ovf2 !== 1'b0 || cnt2 !== 2'd3) begin errors++; $display("FAIL sat_clear got ovf=%0b cnt=%0d want 0/3", ovf2, cnt2); end
    endtask

    task test_reset_in_req;
        loop_en = 1'b0;
        ack = 1'b0;
        evt = 1'b1;
        repeat (3) cyc();
        evt = 1'b0;
        checks++; if (req !== 1'b1 || cnt !== 4'd2) begin errors++; $display("FAIL rstreq_setup got req=%0b cnt=%0d want 1/2", req, cnt); end
        ack = 1'b1;
        rst_b = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstreq_async got req=%0b cnt=%0d busy=%0b want 0/0/0", req, cnt, busy); end
        repeat (2) cyc();
        rst_b = 1'b1;
        evt = 1'b1;
        cyc();
        evt = 1'b0;
        repeat (3) cyc();
        checks++; if (req !== 1'b0 || cnt !== 4'd1) begin errors++; $display("FAIL rstreq_stale_ack got req=%0b cnt=%0d want 0/1", req, cnt); end
        ack = 1'b0;
        cyc();
        checks++; if (req !== 1'b1 || cnt !== 4'd0) begin errors++; $display("FAIL rstreq_launch got req=%0b cnt=%0d want 1/0", req, cnt); end
        ack = 1'b1;
        cyc();
        checks++; if (req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rstreq_ret got req=%0b busy=%0b want 0/1", req, busy); end
        ack = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstreq_idle got busy=%0b want 0", busy); end
    endtask

`ifdef CDC_EVT_TIMEOUT_EN
    task test_timeout;
        loop_en = 1'b0;
        ack = 1'b0;
        evt = 1'b1;
        cyc();
        evt = 1'b0;
        cyc();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL tmo_enter got req=%0b want 1", req); end
        repeat (6) cyc();
        checks++; if (req !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL tmo_early got req=%0b tmo=%0b want 1/0", req, tmo); end
        cyc();
        checks++; if (req !== 1'b0 || tmo !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_abort got req=%0b tmo=%0b busy=%0b want 0/1/0", req, tmo, busy); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear got %0b want 0", tmo); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_simultaneous();
        test_saturation();
        test_reset_in_req();
`ifdef CDC_EVT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
